matmul_host_sequencer: RTL



---
 rtl/matmul_host_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the int8 matmul top level: streams A/B words into the
// shared BRAM port, runs the multiply, then drains C through a credit-limited FIFO.
module matmul_host_sequencer #(
  parameter int DWIDTH          = 8,
  parameter int BB_MAT_MUL_SIZE = 32,
  parameter int AWIDTH          = 7,
  parameter int A_WORDS         = 64,
  parameter int B_WORDS         = 64,
  parameter int C_WORDS         = 32,
  parameter int READ_LATENCY    = 4,
  parameter int TIMEOUT         = 4095
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              go,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                              enable_writing_to_mem,
  output logic                              enable_reading_from_mem,
  output logic [AWIDTH-1:0]                 addr_pi,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
  output logic                              we_a,
  output logic                              we_b,
  output logic                              we_c,
  output logic                              start_mat_mul,
  input  logic                              done_mat_mul,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);

  localparam int W          = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int CW         = $clog2(A_WORDS + B_WORDS + C_WORDS + 1);
  localparam int TW         = $clog2(TIMEOUT + 1);
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [1:0]              beat;
  logic [CW-1:0]           cnt;
  logic [TW-1:0]           timer;
  logic [W-1:0]            data_q;
  logic [AWIDTH-1:0]       addr_q;
  logic [READ_LATENCY-1:0] rd_vld;
  logic [W-1:0]            fifo_mem [FIFO_DEPTH];
  logic [2:0]              wr_ptr, rd_ptr;
  logic [3:0]              occ;
  logic [4:0]              inflight;
  logic                    handshake, last_load, issue, push, pop, last_pop, timeout_hit;
  logic                    done_q, error_q;

  // cnt is the word index while loading and the next read address while draining
  assign handshake   = in_valid && in_ready;
  assign last_load   = (beat == 2'd2) &&
                       ((state == LOAD_A) ? (cnt == CW'(A_WORDS - 1)) : (cnt == CW'(B_WORDS - 1)));
  assign issue       = (state == DRAIN) && (cnt < CW'(C_WORDS)) && (({1'b0, occ} + inflight) < 5'd8);
  assign push        = rd_vld[READ_LATENCY-1];
  assign pop         = out_valid && out_ready;
  assign last_pop    = (state == DRAIN) && pop && (occ == 4'd1) && (inflight == 5'd0) &&
                       (cnt == CW'(C_WORDS));
  assign timeout_hit = (state == RUN) && !done_mat_mul && (timer == TW'(TIMEOUT - 1));

  assign out_valid = (occ != 4'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign done      = done_q;
  assign error     = error_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 5'(rd_vld[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx                = state;
    busy                    = 1'b0;
    in_ready                = 1'b0;
    enable_writing_to_mem   = 1'b0;
    enable_reading_from_mem = 1'b0;
    we_a                    = 1'b0;
    we_b                    = 1'b0;
    we_c                    = 1'b0;
    start_mat_mul           = 1'b0;
    addr_pi                 = '0;
    data_pi                 = '0;
    case (state)
      IDLE: if (go) state_nx = LOAD_A;
      LOAD_A, LOAD_B: begin
        busy                  = 1'b1;
        enable_writing_to_mem = 1'b1;
        in_ready              = (beat == 2'd0);
        we_a                  = (state == LOAD_A) && (beat == 2'd2);
        we_b                  = (state == LOAD_B) && (beat == 2'd2);
        addr_pi               = addr_q;
        data_pi               = data_q;
        if (last_load) state_nx = (state == LOAD_A) ? LOAD_B : RUN;
      end
      RUN: begin
        busy          = 1'b1;
        start_mat_mul = 1'b1;
        we_c          = 1'b1;
        if (done_mat_mul)     state_nx = DRAIN;
        else if (timeout_hit) state_nx = IDLE;
      end
      DRAIN: begin
        busy                    = 1'b1;
        enable_reading_from_mem = 1'b1;
        addr_pi                 = AWIDTH'(cnt);
        if (last_pop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat    <= '0;
      cnt     <= '0;
      timer   <= '0;
      rd_vld  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= last_pop;
      rd_vld <= (rd_vld << 1) | READ_LATENCY'(issue);
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      occ <= occ + 4'(push) - 4'(pop);
      case (state)
        IDLE: if (go) begin
          error_q <= 1'b0;
          cnt     <= '0;
          beat    <= '0;
        end
        LOAD_A, LOAD_B: begin
          timer <= '0;
          case (beat)
            2'd0:    if (handshake) beat <= 2'd1;
            2'd1:    beat <= 2'd2;
            default: begin
              beat <= 2'd0;
              cnt  <= last_load ? '0 : cnt + CW'(1);
            end
          endcase
        end
        RUN: begin
          if (done_mat_mul)     cnt     <= '0;
          else if (timeout_hit) error_q <= 1'b1;
          else                  timer   <= timer + TW'(1);
        end
        DRAIN: if (issue) cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

  // write beat holding registers and FIFO storage carry no reset; outputs are gated by state/occupancy
  always_ff @(posedge clk) begin
    if (state == IDLE && go) begin
      data_q <= '0;
      addr_q <= '0;
    end else if (handshake) begin
      data_q <= in_data;
      addr_q <= AWIDTH'(cnt);
    end
    if (push) fifo_mem[wr_ptr] <= data_from_out_mat;
  end

endmodule
